// File: rtl/wb_unit_if.sv
// Bus bundle between the pipeline and the writeback unit.
// The pipeline side uses the master modport and the writeback unit uses the slave modport.
interface wb_unit_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
);
   logic              alu_valid;
   logic [REG_AW-1:0] alu_rd;
   logic [XLEN-1:0]   alu_result;
   logic              ld_req_valid;
   logic              ld_req_ready;
   logic [REG_AW-1:0] ld_rd;
   logic [2:0]        ld_funct3;
   logic [1:0]        ld_addr_lo;
   logic              mem_rvalid;
   logic [XLEN-1:0]   mem_rdata;
   logic              write_en;
   logic [REG_AW-1:0] write_reg;
   logic [XLEN-1:0]   write_data;
   logic              busy;

   modport master (
      output alu_valid, alu_rd, alu_result,
      output ld_req_valid, ld_rd, ld_funct3, ld_addr_lo,
      output mem_rvalid, mem_rdata,
      input  ld_req_ready, write_en, write_reg, write_data, busy
   );

   modport slave (
      input  alu_valid, alu_rd, alu_result,
      input  ld_req_valid, ld_rd, ld_funct3, ld_addr_lo,
      input  mem_rvalid, mem_rdata,
      output ld_req_ready, write_en, write_reg, write_data, busy
   );
endinterface

// File: rtl/wb_unit.sv
// RV32I writeback unit: sole register-file writer, merging single-cycle ALU results
// with one outstanding load; the ALU wins collisions and the load waits in a hold register.
module wb_unit #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic    clk,
   input  logic    reset_n,
   wb_unit_if.slave wb
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      LD_HOLD  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        lo_q, lo_d;
   logic [XLEN-1:0]   hold_q, hold_d;
   logic              write_en_q, write_en_d;
   logic [REG_AW-1:0] write_reg_q, write_reg_d;
   logic [XLEN-1:0]   write_data_q, write_data_d;
   logic [XLEN-1:0]   fmt_s;

   // Misaligned halfwords select by addr bit 1 only; unknown funct3 codes return the full word.
   function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] w,
                                                input logic [2:0]      f3,
                                                input logic [1:0]      lo);
      logic [7:0]  b;
      logic [15:0] h;
      logic [XLEN-1:0] r;
      b = w[{lo, 3'b000} +: 8];
      if (lo[1]) begin
         h = w[31:16];
      end else begin
         h = w[15:0];
      end
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b100:  r = {24'd0, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b101:  r = {16'd0, h};
         default: r = w;
      endcase
      return r;
   endfunction

   assign fmt_s = fmt_load(wb.mem_rdata, f3_q, lo_q);

   // Next-state and write-port selection; the ALU always owns the port when valid.
   always_comb begin
      state_d      = state_q;
      rd_d         = rd_q;
      f3_d         = f3_q;
      lo_d         = lo_q;
      hold_d       = hold_q;
      write_en_d   = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;

      if (wb.alu_valid) begin
         write_en_d   = (wb.alu_rd != {REG_AW{1'b0}});
         write_reg_d  = wb.alu_rd;
         write_data_d = wb.alu_result;
      end else begin
         write_en_d   = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (wb.ld_req_valid) begin
               rd_d    = wb.ld_rd;
               f3_d    = wb.ld_funct3;
               lo_d    = wb.ld_addr_lo;
               state_d = WAIT_MEM;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_MEM: begin
            if (!wb.mem_rvalid) begin
               state_d = WAIT_MEM;
            end else if (wb.alu_valid) begin
               hold_d  = fmt_s;
               state_d = LD_HOLD;
            end else begin
               write_en_d   = (rd_q != {REG_AW{1'b0}});
               write_reg_d  = rd_q;
               write_data_d = fmt_s;
               state_d      = IDLE;
            end
         end
         LD_HOLD: begin
            if (wb.alu_valid) begin
               state_d = LD_HOLD;
            end else begin
               write_en_d   = (rd_q != {REG_AW{1'b0}});
               write_reg_d  = rd_q;
               write_data_d = hold_q;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, captured load descriptor, hold register and registered write port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         rd_q         <= {REG_AW{1'b0}};
         f3_q         <= 3'b000;
         lo_q         <= 2'b00;
         hold_q       <= {XLEN{1'b0}};
         write_en_q   <= 1'b0;
         write_reg_q  <= {REG_AW{1'b0}};
         write_data_q <= {XLEN{1'b0}};
      end else begin
         state_q      <= state_d;
         rd_q         <= rd_d;
         f3_q         <= f3_d;
         lo_q         <= lo_d;
         hold_q       <= hold_d;
         write_en_q   <= write_en_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   assign wb.write_en     = write_en_q;
   assign wb.write_reg    = write_reg_q;
   assign wb.write_data   = write_data_q;
   assign wb.busy         = (state_q != IDLE);
   assign wb.ld_req_ready = (state_q == IDLE);

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: ALU writes, load formatting, ALU/load collisions,
// x0 suppression and reset during an outstanding load.
module tb_wb_unit;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_errors;

   wb_unit_if #(.XLEN(32), .REG_AW(5)) bus ();

   wb_unit #(.XLEN(32), .REG_AW(5)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .wb      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (obs !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus.alu_valid    = 1'b0;
      bus.alu_rd       = 5'd0;
      bus.alu_result   = 32'd0;
      bus.ld_req_valid = 1'b0;
      bus.ld_rd        = 5'd0;
      bus.ld_funct3    = 3'd0;
      bus.ld_addr_lo   = 2'd0;
      bus.mem_rvalid   = 1'b0;
      bus.mem_rdata    = 32'd0;
   endtask

   task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
      bus.ld_req_valid = 1'b1;
      bus.ld_rd        = rd;
      bus.ld_funct3    = f3;
      bus.ld_addr_lo   = lo;
      tick();
      bus.ld_req_valid = 1'b0;
      chk("ld_busy", {31'd0, bus.busy}, 32'd1);
      chk("ld_ready", {31'd0, bus.ld_req_ready}, 32'd0);
   endtask

   task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] lo, input logic [31:0] data, input logic [31:0] exp);
      issue_load(rd, f3, lo);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = data;
      tick();
      bus.mem_rvalid = 1'b0;
      chk({tag, "_we"}, {31'd0, bus.write_en}, (rd != 5'd0) ? 32'd1 : 32'd0);
      chk({tag, "_reg"}, {27'd0, bus.write_reg}, {27'd0, rd});
      chk({tag, "_data"}, bus.write_data, exp);
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      tick();
      chk({tag, "_we_off"}, {31'd0, bus.write_en}, 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      clear_in();
      reset_n = 1'b0;
      tick();
      tick();
      chk("rst_we", {31'd0, bus.write_en}, 32'd0);
      chk("rst_reg", {27'd0, bus.write_reg}, 32'd0);
      chk("rst_data", bus.write_data, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_ready", {31'd0, bus.ld_req_ready}, 32'd1);
      reset_n = 1'b1;
      tick();

      // ALU write latency and single-cycle strobe
      bus.alu_valid  = 1'b1;
      bus.alu_rd     = 5'd5;
      bus.alu_result = 32'hDEADBEEF;
      tick();
      clear_in();
      chk("alu_we", {31'd0, bus.write_en}, 32'd1);
      chk("alu_reg", {27'd0, bus.write_reg}, 32'd5);
      chk("alu_data", bus.write_data, 32'hDEADBEEF);
      tick();
      chk("alu_we_off", {31'd0, bus.write_en}, 32'd0);

      // Load formatting
      do_load("lb2",  5'd3, 3'b000, 2'd2, 32'h1280FF34, 32'hFFFFFF80);
      do_load("lbu2", 5'd3, 3'b100, 2'd2, 32'h1280FF34, 32'h00000080);
      do_load("lh2",  5'd3, 3'b001, 2'd2, 32'h1280FF34, 32'h00001280);
      do_load("lhu0", 5'd3, 3'b101, 2'd0, 32'h1280FF34, 32'h0000FF34);
      do_load("lh0",  5'd8, 3'b001, 2'd0, 32'h1280FF34, 32'hFFFFFF34);
      do_load("lb3",  5'd8, 3'b000, 2'd3, 32'h1280FF34, 32'h00000012);
      do_load("lb1",  5'd8, 3'b000, 2'd1, 32'h1280FF34, 32'hFFFFFFFF);
      do_load("lh3",  5'd8, 3'b001, 2'd3, 32'h8001FF34, 32'hFFFF8001);
      do_load("f011", 5'd8, 3'b011, 2'd1, 32'h1280FF34, 32'h1280FF34);

      // Collision: ALU first, then held load; a second request while busy is ignored
      issue_load(5'd7, 3'b010, 2'd0);
      bus.ld_req_valid = 1'b1;
      bus.ld_rd        = 5'd20;
      tick();
      bus.ld_req_valid = 1'b0;
      chk("ign_we", {31'd0, bus.write_en}, 32'd0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hCAFEF00D;
      bus.alu_valid  = 1'b1;
      bus.alu_rd     = 5'd9;
      bus.alu_result = 32'h00000011;
      tick();
      clear_in();
      chk("col_alu_we", {31'd0, bus.write_en}, 32'd1);
      chk("col_alu_reg", {27'd0, bus.write_reg}, 32'd9);
      chk("col_alu_data", bus.write_data, 32'h00000011);
      chk("col_busy1", {31'd0, bus.busy}, 32'd1);
      tick();
      chk("col_ld_we", {31'd0, bus.write_en}, 32'd1);
      chk("col_ld_reg", {27'd0, bus.write_reg}, 32'd7);
      chk("col_ld_data", bus.write_data, 32'hCAFEF00D);
      chk("col_busy2", {31'd0, bus.busy}, 32'd0);
      tick();
      chk("col_we_off", {31'd0, bus.write_en}, 32'd0);

      // Held load waits through three more back-to-back ALU writes
      issue_load(5'd4, 3'b101, 2'd2);
      for (int i = 0; i < 4; i++) begin
         bus.mem_rvalid = (i == 0);
         bus.mem_rdata  = 32'hA5A50001;
         bus.alu_valid  = 1'b1;
         bus.alu_rd     = 5'd10 + 5'(i);
         bus.alu_result = 32'd100 + 32'(i);
         tick();
         bus.mem_rvalid = 1'b0;
         bus.mem_rdata  = 32'hFFFFFFFF;
         chk("hold_alu_we", {31'd0, bus.write_en}, 32'd1);
         chk("hold_alu_reg", {27'd0, bus.write_reg}, 32'd10 + 32'(i));
         chk("hold_alu_data", bus.write_data, 32'd100 + 32'(i));
         chk("hold_busy", {31'd0, bus.busy}, 32'd1);
      end
      clear_in();
      tick();
      chk("hold_ld_we", {31'd0, bus.write_en}, 32'd1);
      chk("hold_ld_reg", {27'd0, bus.write_reg}, 32'd4);
      chk("hold_ld_data", bus.write_data, 32'h0000A5A5);
      chk("hold_busy_off", {31'd0, bus.busy}, 32'd0);

      // x0 destinations never strobe
      bus.alu_valid  = 1'b1;
      bus.alu_rd     = 5'd0;
      bus.alu_result = 32'h12345678;
      tick();
      clear_in();
      chk("x0_alu_we", {31'd0, bus.write_en}, 32'd0);
      chk("x0_alu_data", bus.write_data, 32'h12345678);
      do_load("x0_ld", 5'd0, 3'b010, 2'd0, 32'h0BADF00D, 32'h0BADF00D);

      // Reset while waiting for memory drops the load
      issue_load(5'd6, 3'b010, 2'd0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_mid_ready", {31'd0, bus.ld_req_ready}, 32'd1);
      chk("rst_mid_we", {31'd0, bus.write_en}, 32'd0);
      tick();
      reset_n = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h55555555;
      tick();
      clear_in();
      chk("rst_post_we", {31'd0, bus.write_en}, 32'd0);
      chk("rst_post_data", bus.write_data, 32'd0);
      chk("rst_post_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_post_ready", {31'd0, bus.ld_req_ready}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
